pc_unit: RTL and testbench
==========================

# pc_unit

Fetch-stage program-counter unit for the five-stage MIPS pipeline: owns the F-stage PC register and computes every next-PC from D-stage branch/jump decisions, exception entry and `eret`. It is the successor to the purely combinational next-PC logic, now parametrised in reset/vector addresses and op width. It adds a redirect-pending buffer for F-stalls, delay-slot tracking and fetch-address fault detection. It sits between the hazard unit (enable), the D-stage decoder/comparator inputs and the CP0 block (EPC, exception request).

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset
- `EXC_VEC`, 32'h0000_4180, exception entry address
- `IMEM_BASE`, 32'h0000_3000, lowest legal fetch address
- `IMEM_SIZE`, 32'h0000_4000, legal fetch window size in bytes
- `NPC_OP_W`, 4, width of `npc_op`

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `en_f` in 1: F-stage enable from hazard unit; 0 = hold PC
- `d_valid` in 1: D-stage instruction is valid (not a bubble)
- `npc_op` in NPC_OP_W: D-stage op. 0 SEQ, 1 BEQ, 2 J/JAL, 3 JR/JALR, 4 BNE, 5 ERET, 6 BLTZ, 7 BGEZ, 8 BLEZ, 9 BGTZ
- `pc_d` in 32: PC of the D-stage instruction
- `offset` in 32: sign-extended, already shifted branch offset
- `target` in 26: J-type index
- `rs_val`, `rt_val` in 32: forwarded register operands
- `epc` in 32: CP0 EPC
- `exc_req` in 1: CP0 exception entry request
- `pc_f` out 32: current fetch PC
- `bd_f` out 1: instruction at `pc_f` is a delay slot
- `flush` out 1: flush F/D/E, one cycle
- `adel_f` out 1: `pc_f` misaligned or outside the window

## Operation
- Redirect target for a valid D branch/jump:
  - taken branch: `pc_d + 4 + offset`
  - not-taken branch: `pc_d + 8`
  - J: `{pc_d[31:28], target, 2'b00}`
  - JR: `rs_val`
  - ERET: `epc`
- Comparisons:
  - BLTZ/BGEZ/BLEZ/BGTZ are signed compares of `rs_val` against 0.
  - BEQ/BNE compare full 32-bit equality.
  - All adds are 32-bit and wrap modulo 2^32.
- Next-PC priority, highest first:
  1. `exc_req` → `EXC_VEC`
  2. ERET → `epc`
  3. pending redirect
  4. D redirect (ops 1–4, 6–9 with `d_valid`)
  5. `pc_f + 4`
- Ops 10–15 and ops with `d_valid`=0 are treated as SEQ.
- Pending FSM, states IDLE and PEND:
  - IDLE → PEND when a D redirect (non-ERET) arrives with `en_f`=0. The target is latched in `pend_pc` and `bd_f` is latched for the next fetch.
  - PEND → IDLE on the first cycle with `en_f`=1; the PC loads `pend_pc`.
  - A second D redirect while in PEND is ignored. The hazard unit never presents one.
  - `exc_req` or ERET in either state forces IDLE and discards `pend_pc`.
- `exc_req` and ERET take effect even when `en_f`=0. They set the PC, pulse `flush`, and clear `bd_f`.
- `bd_f` is set when the PC advances past a D-stage op in 1–4 or 6–9 with `d_valid`. It clears on the next advance without one.
- `adel_f` is combinational on `pc_f`: `pc_f[1:0] != 0` or `pc_f - IMEM_BASE >= IMEM_SIZE` (unsigned).

## Timing
- Reset values: `pc_f`=`RESET_PC`, `bd_f`=0, `flush`=0, FSM=IDLE, `pend_pc`=0.
- `adel_f` after reset follows `RESET_PC` (0 for the defaults).
- Latency: the decision presented in cycle N appears on `pc_f` after edge N. Redirects have zero bubble; the delay slot is already in F.
- `flush` is registered: high for exactly the cycle after the `exc_req`/ERET edge.
- With `en_f`=0 and no exception/ERET, `pc_f` and `bd_f` hold.
- `rst_n` low mid-PEND returns to IDLE immediately, asynchronously.

## Configuration
- `PC_UNIT_REGIMM_EN`:
  - Defined: ops 6–9 are decoded as above.
  - Undefined: ops 6–9 behave as SEQ, and their comparators are not built.

## Structure
- Shared package `pc_pkg` holds:
  - op encoding constants `NPC_SEQ`…`NPC_BGTZ`
  - FSM state typedef
  - default `RESET_PC`/`EXC_VEC` constants
- One sub-module, `npc_calc`: combinational target/taken computation, reused by the branch-predict work later.

## Test plan
- Reset: release `rst_n` → `pc_f`=0x3000, `bd_f`=0, `flush`=0. With `en_f`=1 for 3 cycles → 0x3004, 0x3008, 0x300C.
- BEQ taken, `pc_d`=0x3008, `offset`=0x10, `rs_val`=`rt_val` → `pc_f`=0x301C next cycle, `bd_f`=1. With `rs_val`≠`rt_val` → 0x3010.
- JR with `rs_val`=0x3100 while `en_f`=0 for 2 cycles → `pc_f` held. `en_f`=1 → 0x3100 next edge.
- `exc_req` during PEND with `en_f`=0 → `pc_f`=0x4180, `flush`=1 for one cycle, `bd_f`=0, pending discarded.
- ERET with `epc`=0x3202 → `pc_f`=0x3202, `flush`=1, `adel_f`=1. JR to 0x8000 → `adel_f`=1.
- With `PC_UNIT_REGIMM_EN`, BLTZ `rs_val`=0xFFFF_FFFF, `pc_d`=0x3000, `offset`=8 → 0x300C. Without the macro → sequential 0x3004 from `pc_f`=0x3000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: next-PC op encodings,
// pending-redirect FSM states and default address constants.
package pc_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IMEM_SIZE_DEFAULT = 32'h0000_4000;

  localparam int unsigned NPC_SEQ  = 0;
  localparam int unsigned NPC_BEQ  = 1;
  localparam int unsigned NPC_J    = 2;
  localparam int unsigned NPC_JR   = 3;
  localparam int unsigned NPC_BNE  = 4;
  localparam int unsigned NPC_ERET = 5;
  localparam int unsigned NPC_BLTZ = 6;
  localparam int unsigned NPC_BGEZ = 7;
  localparam int unsigned NPC_BLEZ = 8;
  localparam int unsigned NPC_BGTZ = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational D-stage redirect decode: decides whether the D instruction
// redirects fetch and computes the target. REGIMM branches need PC_UNIT_REGIMM_EN.
module npc_calc
  import pc_pkg::*;
#(
  parameter int NPC_OP_W = 4
) (
  input  logic                d_valid,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [31:0]         pc_d,
  input  logic [31:0]         offset,
  input  logic [25:0]         target,
  input  logic [31:0]         rs_val,
  input  logic [31:0]         rt_val,
  output logic                redirect,
  output logic                eret,
  output logic [31:0]         redirect_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] j_pc;
  logic        eq;

  assign seq_pc = pc_d + 32'd8;
  assign br_pc  = pc_d + 32'd4 + offset;
  assign j_pc   = {pc_d[31:28], target, 2'b00};
  assign eq     = (rs_val == rt_val);

`ifdef PC_UNIT_REGIMM_EN
  logic signed [31:0] rs_s;
  logic               rs_ltz;
  logic               rs_eqz;

  assign rs_s   = rs_val;
  assign rs_ltz = (rs_s < 32'sd0);
  assign rs_eqz = (rs_s == 32'sd0);
`endif

  always_comb begin
    redirect    = 1'b0;
    eret        = 1'b0;
    redirect_pc = seq_pc;
    if (d_valid) begin
      case (npc_op)
        NPC_OP_W'(NPC_BEQ): begin
          redirect    = 1'b1;
          redirect_pc = eq ? br_pc : seq_pc;
        end
        NPC_OP_W'(NPC_BNE): begin
          redirect    = 1'b1;
          redirect_pc = eq ? seq_pc : br_pc;
        end
        NPC_OP_W'(NPC_J): begin
          redirect    = 1'b1;
          redirect_pc = j_pc;
        end
        NPC_OP_W'(NPC_JR): begin
          redirect    = 1'b1;
          redirect_pc = rs_val;
        end
        NPC_OP_W'(NPC_ERET): eret = 1'b1;
`ifdef PC_UNIT_REGIMM_EN
        NPC_OP_W'(NPC_BLTZ): begin
          redirect    = 1'b1;
          redirect_pc = rs_ltz ? br_pc : seq_pc;
        end
        NPC_OP_W'(NPC_BGEZ): begin
          redirect    = 1'b1;
          redirect_pc = rs_ltz ? seq_pc : br_pc;
        end
        NPC_OP_W'(NPC_BLEZ): begin
          redirect    = 1'b1;
          redirect_pc = (rs_ltz || rs_eqz) ? br_pc : seq_pc;
        end
        NPC_OP_W'(NPC_BGTZ): begin
          redirect    = 1'b1;
          redirect_pc = (rs_ltz || rs_eqz) ? seq_pc : br_pc;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with exception/eret entry, stall-tolerant redirect
// buffer, delay-slot flag and fetch fault check. Optional macro: PC_UNIT_REGIMM_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET_DEFAULT,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEFAULT,
  parameter logic [31:0] IMEM_SIZE = IMEM_SIZE_DEFAULT,
  parameter int          NPC_OP_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_f,
  input  logic                d_valid,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [31:0]         pc_d,
  input  logic [31:0]         offset,
  input  logic [25:0]         target,
  input  logic [31:0]         rs_val,
  input  logic [31:0]         rt_val,
  input  logic [31:0]         epc,
  input  logic                exc_req,
  output logic [31:0]         pc_f,
  output logic                bd_f,
  output logic                flush,
  output logic                adel_f
);

  logic        redirect;
  logic        eret;
  logic [31:0] redirect_pc;

  npc_calc #(
    .NPC_OP_W(NPC_OP_W)
  ) u_npc_calc (
    .d_valid    (d_valid),
    .npc_op     (npc_op),
    .pc_d       (pc_d),
    .offset     (offset),
    .target     (target),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .redirect   (redirect),
    .eret       (eret),
    .redirect_pc(redirect_pc)
  );

  pend_state_t state, state_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] pc_nxt;
  logic        bd_nxt;
  logic        flush_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pend_pc_nxt = pend_pc;
    pc_nxt      = pc_f;
    bd_nxt      = bd_f;
    flush_nxt   = 1'b0;
    if (exc_req || eret) begin
      // Exception/eret win regardless of stall and drop any buffered redirect
      state_nxt   = ST_IDLE;
      pend_pc_nxt = 32'h0;
      pc_nxt      = exc_req ? EXC_VEC : epc;
      bd_nxt      = 1'b0;
      flush_nxt   = 1'b1;
    end else if (state == ST_PEND) begin
      if (en_f) begin
        state_nxt = ST_IDLE;
        pc_nxt    = pend_pc;
        bd_nxt    = 1'b1;
      end
    end else if (redirect) begin
      if (en_f) begin
        pc_nxt = redirect_pc;
        bd_nxt = 1'b1;
      end else begin
        // F is stalled but D will move on: remember where to go
        state_nxt   = ST_PEND;
        pend_pc_nxt = redirect_pc;
      end
    end else if (en_f) begin
      pc_nxt = pc_f + 32'd4;
      bd_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f    <= RESET_PC;
      bd_f    <= 1'b0;
      flush   <= 1'b0;
      pend_pc <= 32'h0;
    end else begin
      pc_f    <= pc_nxt;
      bd_f    <= bd_nxt;
      flush   <= flush_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  logic [31:0] pc_rel;

  assign pc_rel = pc_f - IMEM_BASE;
  assign adel_f = (pc_f[1:0] != 2'b00) || (pc_rel >= IMEM_SIZE);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues the expected F-stage state
// for each edge, a negedge monitor pops and compares. Honours PC_UNIT_REGIMM_EN.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        en_f;
  logic        d_valid;
  logic [3:0]  npc_op;
  logic [31:0] pc_d;
  logic [31:0] offset;
  logic [25:0] target;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] pc_f;
  logic        bd_f;
  logic        flush;
  logic        adel_f;

  pc_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_f   (en_f),
    .d_valid(d_valid),
    .npc_op (npc_op),
    .pc_d   (pc_d),
    .offset (offset),
    .target (target),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .epc    (epc),
    .exc_req(exc_req),
    .pc_f   (pc_f),
    .bd_f   (bd_f),
    .flush  (flush),
    .adel_f (adel_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic        fl;
    logic        ad;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({pc_f, bd_f, flush, adel_f} !== {e.pc, e.bd, e.fl, e.ad}) begin
        failures++;
        $display("FAIL %s: got pc_f=%h bd_f=%b flush=%b adel_f=%b, expected pc_f=%h bd_f=%b flush=%b adel_f=%b",
                 e.nm, pc_f, bd_f, flush, adel_f, e.pc, e.bd, e.fl, e.ad);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic bd, input logic fl,
                      input logic ad, input string nm);
    exp_t e;
    e.pc = pc; e.bd = bd; e.fl = fl; e.ad = ad; e.nm = nm;
    q.push_back(e);
  endtask

  // Expectation applies to the state right after the next rising edge
  task automatic cyc(input logic [31:0] pc, input logic bd, input logic fl,
                     input logic ad, input string nm);
    @(posedge clk);
    push(pc, bd, fl, ad, nm);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [3:0] op, input logic [31:0] pcd,
                       input logic [31:0] off, input logic [25:0] tgt,
                       input logic [31:0] rs, input logic [31:0] rt);
    d_valid = v; npc_op = op; pc_d = pcd; offset = off;
    target = tgt; rs_val = rs; rt_val = rt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en_f = 1'b0; exc_req = 1'b0; epc = 32'h0;
    set_d(1'b0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(32'h3000, 1'b0, 1'b0, 1'b0, "reset");
    @(negedge clk); #1;

    en_f = 1'b1;
    cyc(32'h3004, 0, 0, 0, "seq1");
    cyc(32'h3008, 0, 0, 0, "seq2");
    cyc(32'h300C, 0, 0, 0, "seq3");

    set_d(1, 4'd1, 32'h3008, 32'h10, 26'h0, 32'h5, 32'h5);
    cyc(32'h301C, 1, 0, 0, "beq_taken");
    set_d(1, 4'd1, 32'h3008, 32'h10, 26'h0, 32'h5, 32'h6);
    cyc(32'h3010, 1, 0, 0, "beq_not_taken");
    set_d(0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    cyc(32'h3014, 0, 0, 0, "seq_clears_bd");
    set_d(1, 4'd4, 32'h3010, 32'hFFFF_FFF8, 26'h0, 32'h1, 32'h2);
    cyc(32'h300C, 1, 0, 0, "bne_taken_back");
    set_d(0, 4'd1, 32'h3100, 32'h40, 26'h0, 32'h7, 32'h7);
    cyc(32'h3010, 0, 0, 0, "beq_invalid_is_seq");

    set_d(1, 4'd2, 32'h3010, 32'h0, 26'h000_0C40, 32'h0, 32'h0);
    cyc(32'h3100, 1, 0, 0, "j_target");
    set_d(1, 4'd2, 32'h5000_0000, 32'h0, 26'h3FF_FFFF, 32'h0, 32'h0);
    cyc(32'h5FFF_FFFC, 1, 0, 1, "j_upper_bits");
    set_d(1, 4'd12, 32'h3000, 32'h40, 26'h0, 32'h0, 32'h0);
    cyc(32'h6000_0000, 0, 0, 1, "op12_is_seq");

    // JR arrives while F stalls: held, then released into the target
    en_f = 1'b0;
    set_d(1, 4'd3, 32'h3000, 32'h0, 26'h0, 32'h3100, 32'h0);
    cyc(32'h6000_0000, 0, 0, 1, "jr_stall1");
    cyc(32'h6000_0000, 0, 0, 1, "jr_stall2");
    en_f = 1'b1;
    cyc(32'h3100, 1, 0, 0, "jr_release");
    set_d(0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    cyc(32'h3104, 0, 0, 0, "after_release");

    en_f = 1'b0;
    set_d(1, 4'd3, 32'h3100, 32'h0, 26'h0, 32'h3200, 32'h0);
    cyc(32'h3104, 0, 0, 0, "pend_enter");
    set_d(0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    exc_req = 1'b1;
    cyc(32'h4180, 0, 1, 0, "exc_in_pend");
    exc_req = 1'b0;
    cyc(32'h4180, 0, 0, 0, "exc_flush_one_cycle");
    en_f = 1'b1;
    cyc(32'h4184, 0, 0, 0, "pend_discarded");

    en_f = 1'b0; epc = 32'h3202;
    set_d(1, 4'd5, 32'h4184, 32'h0, 26'h0, 32'h0, 32'h0);
    cyc(32'h3202, 0, 1, 1, "eret_stalled");
    en_f = 1'b1;
    set_d(0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    cyc(32'h3206, 0, 0, 1, "after_eret");

    set_d(1, 4'd3, 32'h3000, 32'h0, 26'h0, 32'h8000, 32'h0);
    cyc(32'h8000, 1, 0, 1, "jr_out_of_window");
    set_d(1, 4'd3, 32'h3000, 32'h0, 26'h0, 32'h6FFC, 32'h0);
    cyc(32'h6FFC, 1, 0, 0, "window_top_edge");
    set_d(1, 4'd3, 32'h3000, 32'h0, 26'h0, 32'h7000, 32'h0);
    cyc(32'h7000, 1, 0, 1, "window_end");
    set_d(1, 4'd3, 32'h3000, 32'h0, 26'h0, 32'h2FFC, 32'h0);
    cyc(32'h2FFC, 1, 0, 1, "below_base");
    set_d(0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    exc_req = 1'b1;
    cyc(32'h4180, 0, 1, 0, "exc_clears_bd");
    exc_req = 1'b0;

    set_d(1, 4'd3, 32'h4180, 32'h0, 26'h0, 32'h3000, 32'h0);
    cyc(32'h3000, 1, 0, 0, "jr_to_base");
    set_d(1, 4'd6, 32'h3000, 32'h8, 26'h0, 32'hFFFF_FFFF, 32'h0);
`ifdef PC_UNIT_REGIMM_EN
    cyc(32'h300C, 1, 0, 0, "bltz_taken");
    set_d(1, 4'd7, 32'h300C, 32'h10, 26'h0, 32'h0, 32'h0);
    cyc(32'h3020, 1, 0, 0, "bgez_zero_taken");
    set_d(1, 4'd9, 32'h3020, 32'h10, 26'h0, 32'h0, 32'h0);
    cyc(32'h3028, 1, 0, 0, "bgtz_zero_not_taken");
    set_d(1, 4'd8, 32'h3028, 32'hFFFF_FFE0, 26'h0, 32'h0, 32'h0);
    cyc(32'h300C, 1, 0, 0, "blez_zero_taken");
`else
    cyc(32'h3004, 0, 0, 0, "bltz_disabled");
    set_d(1, 4'd7, 32'h300C, 32'h10, 26'h0, 32'h0, 32'h0);
    cyc(32'h3008, 0, 0, 0, "bgez_disabled");
    set_d(1, 4'd9, 32'h3020, 32'h10, 26'h0, 32'h5, 32'h0);
    cyc(32'h300C, 0, 0, 0, "bgtz_disabled");
    set_d(1, 4'd8, 32'h3028, 32'hFFFF_FFE0, 26'h0, 32'h0, 32'h0);
    cyc(32'h3010, 0, 0, 0, "blez_disabled");
`endif

    // Asynchronous reset while a redirect is pending
    en_f = 1'b0;
    set_d(1, 4'd3, 32'h3000, 32'h0, 26'h0, 32'h3400, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    push(32'h3000, 1'b0, 1'b0, 1'b0, "async_reset_mid_pend");
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; en_f = 1'b1;
    set_d(0, 4'd0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0);
    cyc(32'h3004, 0, 0, 0, "reset_dropped_pend");

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
